hlink_sched: RTL and testbench

Sequencer/arbiter for the write port of one core's core-to-core link buffer. Per transaction it merges a programmed number of upstream forwarded activation words with a programmed number of the core's own words into the single buffer write channel. Upstream words cannot be stalled, so they always win. Sits between the upstream core's link outputs, the local core datapath, and this core's link-buffer write port.

---
 rtl/hlink_sched.sv | 198 +++++++++++++++++++
 tb/tb_hlink_sched.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hlink_sched.sv
// hlink_sched - write-port sequencer for one core's core-to-core link buffer.
//
// Each transaction merges a programmed number of upstream forwarded words
// with a programmed number of this core's own words into the single link
// buffer write channel. Upstream words cannot be stalled, so they always
// take the write slot. Local words only go in when the upstream side is
// quiet.
//
// Ports:
//   clk          clock
//   rstn         asynchronous active-low reset
//   cfg_start    start pulse, accepted only while idle
//   cfg_loc_len  local word count, latched on an accepted start
//   cfg_fwd_len  upstream word count, latched on an accepted start
//   up_valid     upstream word present (no backpressure)
//   up_data      upstream word
//   loc_valid    local word offered
//   loc_data     local word
//   loc_ready    local word taken this cycle if loc_valid is high
//   buf_wen      link buffer write enable
//   buf_wdata    link buffer write data
//   busy         high while the transaction runs
//   done         one-cycle pulse when the transaction ends
//   err          sticky flag: an upstream word was dropped
//
// Build option: define HLINK_SCHED_OUT_REG_EN to register buf_wen and
// buf_wdata. This adds one cycle of write latency and delays done by one
// cycle so that it follows the last issued write. loc_ready stays
// combinational in both builds.

module hlink_sched #(
   parameter int CACHE_DATA_WIDTH = 128,
   parameter int LEN_W            = 8
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic                        cfg_start,
   input  logic [LEN_W-1:0]            cfg_loc_len,
   input  logic [LEN_W-1:0]            cfg_fwd_len,
   input  logic                        up_valid,
   input  logic [CACHE_DATA_WIDTH-1:0] up_data,
   input  logic                        loc_valid,
   input  logic [CACHE_DATA_WIDTH-1:0] loc_data,
   output logic                        loc_ready,
   output logic                        buf_wen,
   output logic [CACHE_DATA_WIDTH-1:0] buf_wdata,
   output logic                        busy,
   output logic                        done,
   output logic                        err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                      state_r;
   logic [LEN_W-1:0]            loc_len_r;
   logic [LEN_W-1:0]            fwd_len_r;
   logic [LEN_W-1:0]            loc_cnt_r;
   logic [LEN_W-1:0]            fwd_cnt_r;
   logic                        busy_r;
   logic                        done_r;
   logic                        err_r;

   logic                        run_s;
   logic                        up_wr_s;
   logic                        loc_rdy_s;
   logic                        loc_wr_s;
   logic                        drop_s;
   logic                        wen_s;
   logic [CACHE_DATA_WIDTH-1:0] wdata_s;
   logic [LEN_W-1:0]            loc_cnt_nx_s;
   logic [LEN_W-1:0]            fwd_cnt_nx_s;
   logic                        fin_s;

   // Slot arbitration: upstream first, local only when upstream is idle.
   // Counters are compare-gated, so an increment never wraps.
   always_comb begin
      run_s     = (state_r == ST_RUN);
      up_wr_s   = run_s && up_valid && (fwd_cnt_r < fwd_len_r);
      loc_rdy_s = run_s && !up_valid && (loc_cnt_r < loc_len_r);
      loc_wr_s  = loc_rdy_s && loc_valid;
      // Any upstream word that cannot be written is lost for good.
      drop_s    = up_valid && !up_wr_s;
      if (up_wr_s) begin
         wen_s   = 1'b1;
         wdata_s = up_data;
      end else if (loc_wr_s) begin
         wen_s   = 1'b1;
         wdata_s = loc_data;
      end else begin
         wen_s   = 1'b0;
         wdata_s = {CACHE_DATA_WIDTH{1'b0}};
      end
      loc_cnt_nx_s = loc_cnt_r + {{(LEN_W-1){1'b0}}, loc_wr_s};
      fwd_cnt_nx_s = fwd_cnt_r + {{(LEN_W-1){1'b0}}, up_wr_s};
      // Completion includes a word written in this very cycle.
      fin_s = (loc_cnt_nx_s == loc_len_r) && (fwd_cnt_nx_s == fwd_len_r);
   end

   // Transaction FSM with registered busy/done and the word counters.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r   <= ST_IDLE;
         loc_len_r <= {LEN_W{1'b0}};
         fwd_len_r <= {LEN_W{1'b0}};
         loc_cnt_r <= {LEN_W{1'b0}};
         fwd_cnt_r <= {LEN_W{1'b0}};
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done_r <= 1'b0;
               if (cfg_start) begin
                  state_r   <= ST_RUN;
                  loc_len_r <= cfg_loc_len;
                  fwd_len_r <= cfg_fwd_len;
                  loc_cnt_r <= {LEN_W{1'b0}};
                  fwd_cnt_r <= {LEN_W{1'b0}};
                  busy_r    <= 1'b1;
               end else begin
                  busy_r <= 1'b0;
               end
            end
            ST_RUN: begin
               loc_cnt_r <= loc_cnt_nx_s;
               fwd_cnt_r <= fwd_cnt_nx_s;
               if (fin_s) begin
                  state_r <= ST_DONE;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
               end else begin
                  busy_r  <= 1'b1;
                  done_r  <= 1'b0;
               end
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   // Sticky drop flag; a drop in the start cycle beats the start clear.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         err_r <= 1'b0;
      end else if (drop_s) begin
         err_r <= 1'b1;
      end else if ((state_r == ST_IDLE) && cfg_start) begin
         err_r <= 1'b0;
      end else begin
         err_r <= err_r;
      end
   end

   assign loc_ready = loc_rdy_s;
   assign busy      = busy_r;
   assign err       = err_r;

`ifdef HLINK_SCHED_OUT_REG_EN
   logic                        wen_r;
   logic [CACHE_DATA_WIDTH-1:0] wdata_r;
   logic                        done_d_r;

   // Output register stage for the write port, plus matching done delay.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wen_r    <= 1'b0;
         wdata_r  <= {CACHE_DATA_WIDTH{1'b0}};
         done_d_r <= 1'b0;
      end else begin
         wen_r    <= wen_s;
         wdata_r  <= wdata_s;
         done_d_r <= done_r;
      end
   end

   assign buf_wen   = wen_r;
   assign buf_wdata = wdata_r;
   assign done      = done_d_r;
`else
   assign buf_wen   = wen_s;
   assign buf_wdata = wdata_s;
   assign done      = done_r;
`endif

endmodule

// File: tb/tb_hlink_sched.sv
// Self-checking bench for hlink_sched. Expected writes (data and the cycle
// they must appear in) are queued as stimulus is driven; a negedge monitor
// pops and compares every write the DUT issues.

module tb_hlink_sched;

`ifdef HLINK_SCHED_OUT_REG_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 0;
`endif

   logic         clk;
   logic         rstn;
   logic         cfg_start;
   logic [7:0]   cfg_loc_len;
   logic [7:0]   cfg_fwd_len;
   logic         up_valid;
   logic [127:0] up_data;
   logic         loc_valid;
   logic [127:0] loc_data;
   logic         loc_ready;
   logic         buf_wen;
   logic [127:0] buf_wdata;
   logic         busy;
   logic         done;
   logic         err;

   typedef struct {
      logic [127:0] data;
      int           cyc;
   } exp_t;

   exp_t sb_q[$];
   int   cyc        = 0;
   int   tests_run  = 0;
   int   tests_fail = 0;

   hlink_sched #(.CACHE_DATA_WIDTH(128), .LEN_W(8)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .cfg_start   (cfg_start),
      .cfg_loc_len (cfg_loc_len),
      .cfg_fwd_len (cfg_fwd_len),
      .up_valid    (up_valid),
      .up_data     (up_data),
      .loc_valid   (loc_valid),
      .loc_data    (loc_data),
      .loc_ready   (loc_ready),
      .buf_wen     (buf_wen),
      .buf_wdata   (buf_wdata),
      .busy        (busy),
      .done        (done),
      .err         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Write monitor: every issued write must match the head of the queue.
   always @(negedge clk) begin
      if (buf_wen === 1'b1) begin
         if (sb_q.size() == 0) begin
            check_val("unexp_wr", {127'd0, buf_wen}, 128'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check_val("wr_data", buf_wdata, e.data);
            check_val("wr_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_wr(input logic [127:0] d);
      sb_q.push_back('{data: d, cyc: cyc + LAT});
   endtask

   task automatic idle_cycles(input int n);
      cfg_start = 1'b0;
      up_valid  = 1'b0;
      loc_valid = 1'b0;
      repeat (n) step();
   endtask

   task automatic start_txn(input logic [7:0] ll, input logic [7:0] fl);
      cfg_start   = 1'b1;
      cfg_loc_len = ll;
      cfg_fwd_len = fl;
      step();
      cfg_start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn        = 1'b0;
      cfg_start   = 1'b0;
      cfg_loc_len = 8'd0;
      cfg_fwd_len = 8'd0;
      up_valid    = 1'b0;
      up_data     = 128'd0;
      loc_valid   = 1'b0;
      loc_data    = 128'd0;
      step();
      step();
      check_val("rst_wen",   {127'd0, buf_wen},   128'd0);
      check_val("rst_wdata", buf_wdata,           128'd0);
      check_val("rst_rdy",   {127'd0, loc_ready}, 128'd0);
      check_val("rst_busy",  {127'd0, busy},      128'd0);
      check_val("rst_done",  {127'd0, done},      128'd0);
      check_val("rst_err",   {127'd0, err},       128'd0);
      rstn = 1'b1;
      step();

      // T1: three local words back to back, no upstream.
      start_txn(8'd3, 8'd0);
      loc_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         loc_data = 128'h1000 + 128'(i);
         exp_wr(loc_data);
         @(negedge clk);
         check_val("t1_busy", {127'd0, busy},      128'd1);
         check_val("t1_rdy",  {127'd0, loc_ready}, 128'd1);
         check_val("t1_done", {127'd0, done},      128'd0);
         step();
      end
      loc_data = 128'h1FFF;
      @(negedge clk);
      check_val("t1_busy_end", {127'd0, busy},      128'd0);
      check_val("t1_done_a",   {127'd0, done},      (LAT == 0) ? 128'd1 : 128'd0);
      check_val("t1_rdy_end",  {127'd0, loc_ready}, 128'd0);
      step();
      @(negedge clk);
      check_val("t1_done_b",   {127'd0, done},      (LAT == 1) ? 128'd1 : 128'd0);
      idle_cycles(2);

      // T2: interleave up, loc, up, loc.
      start_txn(8'd2, 8'd2);
      loc_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         up_valid = (i % 2 == 0);
         up_data  = 128'hA000 + 128'(i);
         loc_data = 128'hB000 + 128'(i);
         exp_wr(up_valid ? up_data : loc_data);
         @(negedge clk);
         check_val("t2_rdy", {127'd0, loc_ready}, (i % 2 == 0) ? 128'd0 : 128'd1);
         check_val("t2_err", {127'd0, err}, 128'd0);
         step();
      end
      up_valid  = 1'b0;
      loc_valid = 1'b0;
      @(negedge clk);
      check_val("t2_done", {127'd0, done}, (LAT == 0) ? 128'd1 : 128'd0);
      check_val("t2_err_end", {127'd0, err}, 128'd0);
      idle_cycles(3);

      // T3: upstream word while idle is dropped; next start clears err.
      up_valid = 1'b1;
      up_data  = 128'hA5;
      @(negedge clk);
      check_val("t3_wen_idle", {127'd0, buf_wen}, 128'd0);
      step();
      up_valid = 1'b0;
      @(negedge clk);
      check_val("t3_err_set", {127'd0, err}, 128'd1);
      start_txn(8'd1, 8'd0);
      loc_valid = 1'b1;
      loc_data  = 128'hC001;
      exp_wr(loc_data);
      @(negedge clk);
      check_val("t3_err_clr", {127'd0, err}, 128'd0);
      step();
      idle_cycles(3);

      // T4: second upstream word overruns fwd_len and is dropped.
      start_txn(8'd1, 8'd1);
      loc_valid = 1'b1;
      loc_data  = 128'hD0;
      up_valid  = 1'b1;
      up_data   = 128'hE0;
      exp_wr(up_data);
      step();
      up_data = 128'hE1;
      @(negedge clk);
      check_val("t4_rdy_drop", {127'd0, loc_ready}, 128'd0);
      step();
      up_valid = 1'b0;
      loc_data = 128'hD2;
      exp_wr(loc_data);
      @(negedge clk);
      check_val("t4_err", {127'd0, err}, 128'd1);
      check_val("t4_busy", {127'd0, busy}, 128'd1);
      step();
      loc_valid = 1'b0;
      @(negedge clk);
      check_val("t4_done_a", {127'd0, done}, (LAT == 0) ? 128'd1 : 128'd0);
      step();
      @(negedge clk);
      check_val("t4_done_b", {127'd0, done}, (LAT == 1) ? 128'd1 : 128'd0);
      idle_cycles(2);

      // T5: zero lengths; a start while busy is ignored.
      start_txn(8'd0, 8'd0);
      cfg_start   = 1'b1;
      cfg_loc_len = 8'd5;
      cfg_fwd_len = 8'd5;
      @(negedge clk);
      check_val("t5_busy", {127'd0, busy}, 128'd1);
      step();
      cfg_start = 1'b0;
      @(negedge clk);
      check_val("t5_busy_off", {127'd0, busy}, 128'd0);
      check_val("t5_done_a", {127'd0, done}, (LAT == 0) ? 128'd1 : 128'd0);
      step();
      @(negedge clk);
      check_val("t5_no_restart", {127'd0, busy}, 128'd0);
      check_val("t5_done_b", {127'd0, done}, (LAT == 1) ? 128'd1 : 128'd0);
      idle_cycles(2);

      // T6: reset mid-transaction after one of four words.
      start_txn(8'd4, 8'd0);
      loc_valid = 1'b1;
      loc_data  = 128'hF0;
      exp_wr(loc_data);
      step();
      loc_valid = 1'b0;
      @(negedge clk);
      check_val("t6_rdy_run", {127'd0, loc_ready}, 128'd1);
      step();
      rstn = 1'b0;
      #1;
      check_val("t6_wen",   {127'd0, buf_wen},   128'd0);
      check_val("t6_wdata", buf_wdata,           128'd0);
      check_val("t6_rdy",   {127'd0, loc_ready}, 128'd0);
      check_val("t6_busy",  {127'd0, busy},      128'd0);
      check_val("t6_done",  {127'd0, done},      128'd0);
      check_val("t6_err",   {127'd0, err},       128'd0);
      step();
      rstn = 1'b1;
      step();
      start_txn(8'd1, 8'd0);
      loc_valid = 1'b1;
      loc_data  = 128'hF1;
      exp_wr(loc_data);
      step();
      loc_data = 128'hF2;
      @(negedge clk);
      check_val("t6_done_after", {127'd0, done}, (LAT == 0) ? 128'd1 : 128'd0);
      idle_cycles(4);

      check_val("sb_empty", sb_q.size(), 128'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
      $finish;
   end

endmodule
